// File: rtl/mul_writeback_stage.sv
// Multiply writeback stage: tracks rd through the multiplier latency,
// buffers results in an in-order FIFO and issues credit-based stalls.
module mul_writeback_stage #(
  parameter int unsigned LATENCY    = 2,
  parameter int unsigned FIFO_DEPTH = 4,
  parameter int unsigned XLEN       = 32
) (
  input  logic            clk_i,
  input  logic            rst_ni,
  input  logic            opcode_valid_i,
  input  logic [31:0]     opcode_opcode_i,
  input  logic            hold_i,
  input  logic [XLEN-1:0] mul_result_i,
  input  logic            wb_ready_i,
  output logic            wb_valid_o,
  output logic [4:0]      wb_rd_o,
  output logic [XLEN-1:0] wb_value_o,
  output logic            stall_o,
  output logic            busy_o
);

  localparam int unsigned PW = (FIFO_DEPTH > 1) ? $clog2(FIFO_DEPTH) : 1;
  localparam int unsigned CW = $clog2(FIFO_DEPTH + 1);
  localparam int unsigned SW = $clog2(FIFO_DEPTH + LATENCY + 1);

  logic            is_mul;
  logic [4:0]      rd_dec;
  logic            accept;
  logic            push;
  logic            pop;

  logic [LATENCY-1:0] tv_q;
  logic [4:0]         trd_q [LATENCY];

  logic [4:0]      frd_q  [FIFO_DEPTH];
  logic [XLEN-1:0] fval_q [FIFO_DEPTH];
  logic [PW-1:0]   wptr_q, wptr_d;
  logic [PW-1:0]   rptr_q, rptr_d;
  logic [CW-1:0]   cnt_q, cnt_d;

  logic [SW-1:0]   inflight;
  logic [SW-1:0]   used;

  function automatic logic [PW-1:0] ptr_inc(input logic [PW-1:0] p);
    return (p == PW'(FIFO_DEPTH - 1)) ? '0 : p + 1'b1;
  endfunction

  // Decode MUL/MULH/MULHSU/MULHU (funct3[2]=0 excludes DIV/REM)
  always_comb begin
    is_mul = (opcode_opcode_i[6:0] == 7'b0110011)
           & (opcode_opcode_i[31:25] == 7'b0000001)
           & ~opcode_opcode_i[14];
    rd_dec = opcode_opcode_i[11:7];
  end

  // Credit accounting: every tag stage holds a FIFO slot in reserve
  always_comb begin
    inflight = '0;
    for (int i = 0; i < LATENCY; i++) begin
      inflight = inflight + SW'(tv_q[i]);
    end
    used = inflight + SW'(cnt_q);
  end

  assign stall_o = (used >= SW'(FIFO_DEPTH));
  assign busy_o  = (inflight != '0) | (cnt_q != '0);
  assign accept  = opcode_valid_i & is_mul & ~hold_i & ~stall_o;
  assign push    = ~hold_i & tv_q[LATENCY-1]
                 & (trd_q[LATENCY-1] != 5'd0);
  assign pop     = (cnt_q != '0) & wb_ready_i;

  // FIFO pointer and occupancy next-state
  always_comb begin
    wptr_d = push ? ptr_inc(wptr_q) : wptr_q;
    rptr_d = pop  ? ptr_inc(rptr_q) : rptr_q;
    cnt_d  = cnt_q;
    unique case ({push, pop})
      2'b10:   cnt_d = cnt_q + 1'b1;
      2'b01:   cnt_d = cnt_q - 1'b1;
      default: cnt_d = cnt_q;
    endcase
  end

  // Tag pipeline shadows the multiplier; freezes on hold
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      tv_q <= '0;
      for (int i = 0; i < LATENCY; i++) trd_q[i] <= '0;
    end else if (!hold_i) begin
      tv_q[0]  <= accept;
      trd_q[0] <= rd_dec;
      for (int i = 1; i < LATENCY; i++) begin
        tv_q[i]  <= tv_q[i-1];
        trd_q[i] <= trd_q[i-1];
      end
    end
  end

  // Writeback FIFO storage, pointers and count
  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      wptr_q <= '0;
      rptr_q <= '0;
      cnt_q  <= '0;
      for (int i = 0; i < FIFO_DEPTH; i++) begin
        frd_q[i]  <= '0;
        fval_q[i] <= '0;
      end
    end else begin
      if (push) begin
        frd_q[wptr_q]  <= trd_q[LATENCY-1];
        fval_q[wptr_q] <= mul_result_i;
      end
      wptr_q <= wptr_d;
      rptr_q <= rptr_d;
      cnt_q  <= cnt_d;
    end
  end

  assign wb_valid_o = (cnt_q != '0);
  assign wb_rd_o    = frd_q[rptr_q];
  assign wb_value_o = fval_q[rptr_q];

  // Credits make a push into a full FIFO without a pop impossible
  a_no_overflow : assert property (
    @(posedge clk_i) disable iff (!rst_ni)
      !(push && (cnt_q == CW'(FIFO_DEPTH)) && !pop)
  );

endmodule

// File: tb/tb_mul_writeback_stage.sv
// Bench for mul_writeback_stage: decode table, directed corner
// sequences, then random traffic against a queue-based model.
module tb_mul_writeback_stage;

  localparam int L = 2;
  localparam int D = 4;

  logic        clk_i = 1'b0;
  logic        rst_ni;
  logic        opcode_valid_i;
  logic [31:0] opcode_opcode_i;
  logic        hold_i;
  logic [31:0] mul_result_i;
  logic        wb_ready_i;
  logic        wb_valid_o;
  logic [4:0]  wb_rd_o;
  logic [31:0] wb_value_o;
  logic        stall_o;
  logic        busy_o;

  logic [31:0] a_i, b_i;

  int n_cmp = 0;
  int n_bad = 0;

  mul_writeback_stage #(
    .LATENCY(L), .FIFO_DEPTH(D), .XLEN(32)
  ) dut (
    .clk_i(clk_i), .rst_ni(rst_ni),
    .opcode_valid_i(opcode_valid_i),
    .opcode_opcode_i(opcode_opcode_i),
    .hold_i(hold_i), .mul_result_i(mul_result_i),
    .wb_ready_i(wb_ready_i), .wb_valid_o(wb_valid_o),
    .wb_rd_o(wb_rd_o), .wb_value_o(wb_value_o),
    .stall_o(stall_o), .busy_o(busy_o)
  );

  always #5 clk_i = ~clk_i;

  function automatic logic [31:0] ref_mul(
    input logic [31:0] op, input logic [31:0] a,
    input logic [31:0] b);
    logic [63:0] sa, sb, ua, ub, r;
    sa = {{32{a[31]}}, a};
    sb = {{32{b[31]}}, b};
    ua = {32'b0, a};
    ub = {32'b0, b};
    case (op[13:12])
      2'd1:    begin r = sa * sb; return r[63:32]; end
      2'd2:    begin r = sa * ub; return r[63:32]; end
      2'd3:    begin r = ua * ub; return r[63:32]; end
      default: begin r = ua * ub; return r[31:0];  end
    endcase
  endfunction

  function automatic logic [31:0] enc(
    input logic [6:0] f7, input logic [2:0] f3,
    input logic [4:0] rd, input logic [6:0] opc);
    return {f7, 5'd11, 5'd10, f3, rd, opc};
  endfunction

  // Stand-in for the real multiplier: L stages, frozen by hold
  logic [31:0] mp [L];
  always_ff @(posedge clk_i) begin
    if (!hold_i) begin
      mp[0] <= ref_mul(opcode_opcode_i, a_i, b_i);
      for (int i = 1; i < L; i++) mp[i] <= mp[i-1];
    end
  end
  assign mul_result_i = mp[L-1];

  task automatic chk(input string n, input logic [63:0] act,
                     input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h want %0h", n, act, exp);
    end
  endtask

  task automatic cyc();
    @(posedge clk_i);
    @(negedge clk_i);
  endtask

  task automatic drive(input logic [31:0] op, input logic [31:0] a,
                       input logic [31:0] b);
    opcode_valid_i  = 1'b1;
    opcode_opcode_i = op;
    a_i = a;
    b_i = b;
  endtask

  task automatic do_reset();
    @(negedge clk_i);
    rst_ni = 1'b0;
    cyc();
    rst_ni = 1'b1;
    cyc();
  endtask

  typedef struct {
    logic [31:0] op;
    logic [31:0] a;
    logic [31:0] b;
    bit          ev;
    logic [4:0]  rd;
    logic [31:0] val;
  } vec_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] v;
    int          rem;
  } fl_t;

  typedef struct {
    logic [4:0]  rd;
    logic [31:0] v;
  } fe_t;

  fl_t fl[$];
  fe_t fq[$];

  // Reference: ops count down their latency on unheld edges
  task automatic model_edge();
    bit   mstall, acc, is_m;
    fl_t  e;
    mstall = (fl.size() + fq.size()) >= D;
    is_m = opcode_opcode_i[6:0] == 7'h33
        && opcode_opcode_i[31:25] == 7'h01
        && opcode_opcode_i[14] == 1'b0;
    acc = opcode_valid_i && is_m && !hold_i && !mstall;
    if (fq.size() != 0 && wb_ready_i) void'(fq.pop_front());
    if (!hold_i) begin
      foreach (fl[i]) fl[i].rem--;
      while (fl.size() != 0 && fl[0].rem == 0) begin
        e = fl.pop_front();
        if (e.rd != 0) fq.push_back('{e.rd, e.v});
      end
      if (acc) begin
        fl.push_back('{opcode_opcode_i[11:7],
          ref_mul(opcode_opcode_i, a_i, b_i), L});
      end
    end
  endtask

  initial begin
    #2_000_000;
    $display("FAIL timeout: got hang want finish");
    $fatal(1, "timeout");
  end

  initial begin
    vec_t tbl[8];
    logic [4:0] got[$];
    logic [31:0] mulx;
    bit acc;

    mulx = 32'h02B50533;
    tbl[0] = '{mulx, 32'h80000001, 32'h00010002,
               1'b1, 5'd10, 32'h00010002};
    tbl[1] = '{enc(7'h01, 3'd1, 5'd9, 7'h33), 32'hFFFFFFFE,
               32'h00000003, 1'b1, 5'd9, 32'h0};
    tbl[2] = '{enc(7'h01, 3'd2, 5'd8, 7'h33), 32'hFFFFFFFF,
               32'hFFFFFFFF, 1'b1, 5'd8, 32'h0};
    tbl[3] = '{enc(7'h01, 3'd3, 5'd7, 7'h33), 32'hFFFFFFFF,
               32'hFFFFFFFF, 1'b1, 5'd7, 32'h0};
    tbl[4] = '{enc(7'h01, 3'd4, 5'd5, 7'h33), 32'd100,
               32'd7, 1'b0, 5'd5, 32'h0};
    tbl[5] = '{enc(7'h00, 3'd0, 5'd6, 7'h33), 32'd3,
               32'd4, 1'b0, 5'd6, 32'h0};
    tbl[6] = '{enc(7'h01, 3'd0, 5'd0, 7'h33), 32'd3,
               32'd5, 1'b0, 5'd0, 32'h0};
    tbl[7] = '{enc(7'h01, 3'd0, 5'd4, 7'h3B), 32'd3,
               32'd5, 1'b0, 5'd4, 32'h0};
    for (int i = 1; i < 4; i++)
      tbl[i].val = ref_mul(tbl[i].op, tbl[i].a, tbl[i].b);

    rst_ni = 1'b0;
    opcode_valid_i = 1'b0;
    opcode_opcode_i = '0;
    hold_i = 1'b0;
    wb_ready_i = 1'b0;
    a_i = '0;
    b_i = '0;
    #3;
    chk("rst_valid", wb_valid_o, 0);
    chk("rst_rd", wb_rd_o, 0);
    chk("rst_value", wb_value_o, 0);
    chk("rst_stall", stall_o, 0);
    chk("rst_busy", busy_o, 0);
    do_reset();

    // Decode table: latency, payload, single-cycle presentation
    wb_ready_i = 1'b1;
    foreach (tbl[k]) begin
      drive(tbl[k].op, tbl[k].a, tbl[k].b);
      cyc();
      opcode_valid_i = 1'b0;
      repeat (L) begin
        chk($sformatf("t%0d_early", k), wb_valid_o, 0);
        cyc();
      end
      chk($sformatf("t%0d_valid", k), wb_valid_o, tbl[k].ev);
      if (tbl[k].ev) begin
        chk($sformatf("t%0d_rd", k), wb_rd_o, tbl[k].rd);
        chk($sformatf("t%0d_val", k), wb_value_o, tbl[k].val);
      end
      cyc();
      chk($sformatf("t%0d_once", k), wb_valid_o, 0);
      chk($sformatf("t%0d_idle", k), busy_o, 0);
      chk($sformatf("t%0d_nostall", k), stall_o, 0);
    end

    // Hold for 3 cycles right after accept
    drive(mulx, 32'h80000001, 32'h00010002);
    cyc();
    opcode_valid_i = 1'b0;
    hold_i = 1'b1;
    repeat (3) cyc();
    hold_i = 1'b0;
    repeat (L) begin
      chk("hold_early", wb_valid_o, 0);
      cyc();
    end
    chk("hold_valid", wb_valid_o, 1);
    chk("hold_val", wb_value_o, 32'h00010002);
    cyc();
    chk("hold_nodup", wb_valid_o, 0);

    // Backpressure: four credits, fifth waits for a pop
    wb_ready_i = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      chk($sformatf("bp_stall%0d", i), stall_o, i == 5);
      drive(enc(7'h01, 3'd0, 5'(i), 7'h33), 32'(i), 32'd3);
      cyc();
    end
    repeat (2) cyc();
    chk("bp_full", stall_o, 1);
    chk("bp_head", wb_rd_o, 1);
    wb_ready_i = 1'b1;
    for (int c = 0; c < 20 && got.size() < 5; c++) begin
      if (wb_valid_o) got.push_back(wb_rd_o);
      acc = opcode_valid_i && !stall_o;
      cyc();
      if (acc) opcode_valid_i = 1'b0;
    end
    chk("bp_count", got.size(), 5);
    foreach (got[k]) chk($sformatf("bp_order%0d", k), got[k], k + 1);
    chk("bp_idle", busy_o, 0);

    // Push and pop on the same edge
    wb_ready_i = 1'b0;
    drive(enc(7'h01, 3'd0, 5'd3, 7'h33), 32'd6, 32'd7);
    cyc();
    opcode_valid_i = 1'b0;
    repeat (L) cyc();
    chk("pp_head0", wb_rd_o, 3);
    drive(enc(7'h01, 3'd0, 5'd4, 7'h33), 32'd9, 32'd9);
    cyc();
    opcode_valid_i = 1'b0;
    repeat (L - 1) cyc();
    chk("pp_pre", wb_valid_o, 1);
    wb_ready_i = 1'b1;
    cyc();
    chk("pp_valid", wb_valid_o, 1);
    chk("pp_rd", wb_rd_o, 4);
    chk("pp_val", wb_value_o, 81);
    cyc();
    chk("pp_drain", wb_valid_o, 0);

    // Reset while ops are in the pipe and the FIFO
    wb_ready_i = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      drive(enc(7'h01, 3'd0, 5'(i), 7'h33), 32'd2, 32'd2);
      cyc();
    end
    opcode_valid_i = 1'b0;
    chk("mr_pre", wb_valid_o, 1);
    #1 rst_ni = 1'b0;
    #1;
    chk("mr_valid", wb_valid_o, 0);
    chk("mr_rd", wb_rd_o, 0);
    chk("mr_value", wb_value_o, 0);
    chk("mr_stall", stall_o, 0);
    chk("mr_busy", busy_o, 0);
    @(negedge clk_i);
    rst_ni = 1'b1;
    wb_ready_i = 1'b1;
    repeat (4) begin
      cyc();
      chk("mr_after", wb_valid_o, 0);
      chk("mr_busy_after", busy_o, 0);
    end

    // Random traffic against the queue model
    do_reset();
    fl.delete();
    fq.delete();
    for (int c = 0; c < 600; c++) begin
      chk("r_valid", wb_valid_o, fq.size() != 0);
      if (fq.size() != 0) begin
        chk("r_rd", wb_rd_o, fq[0].rd);
        chk("r_val", wb_value_o, fq[0].v);
      end
      chk("r_stall", stall_o, (fl.size() + fq.size()) >= D);
      chk("r_busy", busy_o, (fl.size() + fq.size()) != 0);
      opcode_valid_i = ($urandom_range(9) < 7);
      case ($urandom_range(5))
        0: opcode_opcode_i = enc(7'h01, 3'($urandom_range(7)),
                                 5'($urandom), 7'h33);
        1: opcode_opcode_i = $urandom;
        2: opcode_opcode_i = enc(7'h01, 3'($urandom_range(3)),
                                 5'd0, 7'h33);
        default: opcode_opcode_i = enc(7'h01,
                   3'($urandom_range(3)),
                   5'($urandom_range(31, 1)), 7'h33);
      endcase
      a_i = $urandom;
      b_i = $urandom;
      hold_i = ($urandom_range(9) < 2);
      wb_ready_i = ($urandom_range(9) < 6);
      @(posedge clk_i);
      model_edge();
      @(negedge clk_i);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***",
             n_cmp, n_bad);
    $finish;
  end

endmodule
